serial_bit_feeder: RTL and testbench



---
 rtl/serial_bit_feeder_if.sv | 12 +
 rtl/serial_bit_feeder.sv | 99 +++++++++
 tb/tb_serial_bit_feeder.sv | 108 ++++++++++
 3 files changed

// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if: word handshake in, framed serial bit stream out
interface serial_bit_feeder_if #(parameter int WIDTH = 6);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic x;
  logic x_active;
  logic busy;
  logic frame_done;
  modport master(output din, din_valid, input din_ready, x, x_active, busy, frame_done);
  modport slave(input din, din_valid, output din_ready, x, x_active, busy, frame_done);
endinterface

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel word to framed serial bits with optional even parity and idle gap
module serial_bit_feeder #(
  parameter int WIDTH = 6,
  parameter int MSB_FIRST = 0,
  parameter int PARITY_EN = 1,
  parameter int GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic clk,
  input logic rst,
  serial_bit_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] gap, gap_n;
  logic par, par_n, x_n, act_n, rdy_n, done_n, end_frame;
  // sr holds only the bits not yet sent, so the next bit is always at the same end
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    gap_n = gap;
    par_n = par;
    x_n = IDLE_LEVEL;
    act_n = 1'b0;
    rdy_n = 1'b0;
    done_n = 1'b0;
    end_frame = 1'b0;
    case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (bus.din_valid && bus.din_ready) begin
          state_n = SHIFT;
          sr_n = MSB_FIRST != 0 ? bus.din << 1 : bus.din >> 1;
          x_n = MSB_FIRST != 0 ? bus.din[WIDTH-1] : bus.din[0];
          par_n = ^bus.din;
          cnt_n = CW'(1);
          act_n = 1'b1;
          rdy_n = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt != CW'(WIDTH)) begin
          x_n = MSB_FIRST != 0 ? sr[WIDTH-1] : sr[0];
          sr_n = MSB_FIRST != 0 ? sr << 1 : sr >> 1;
          cnt_n = cnt + 1'b1;
          act_n = 1'b1;
        end else if (PARITY_EN != 0) begin
          x_n = par;
          act_n = 1'b1;
          state_n = PARITY;
        end else end_frame = 1'b1;
      end
      PARITY: end_frame = 1'b1;
      GAP: begin
        state_n = gap == 4'(GAP_CYCLES) ? IDLE : GAP;
        rdy_n = gap == 4'(GAP_CYCLES);
        gap_n = gap == 4'(GAP_CYCLES) ? 4'd0 : gap + 4'd1;
      end
      default: state_n = IDLE;
    endcase
    // the frame-end cycle is the first of the gap, so gap starts counting at 1
    if (end_frame) begin
      done_n = 1'b1;
      cnt_n = '0;
      gap_n = GAP_CYCLES > 0 ? 4'd1 : 4'd0;
      state_n = GAP_CYCLES > 0 ? GAP : IDLE;
      rdy_n = GAP_CYCLES == 0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      gap <= '0;
      par <= 1'b0;
      bus.x <= IDLE_LEVEL;
      bus.x_active <= 1'b0;
      bus.din_ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      gap <= gap_n;
      par <= par_n;
      bus.x <= x_n;
      bus.x_active <= act_n;
      bus.din_ready <= rdy_n;
      bus.busy <= state_n != IDLE;
      bus.frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: three configurations driven with random words against a frame-list model
module tb_serial_bit_feeder;
  localparam int N = 3;
  localparam int MSBS [N] = '{0, 1, 0};
  localparam int PARS [N] = '{1, 1, 0};
  localparam int GAPS [N] = '{1, 3, 0};
  localparam int IDLS [N] = '{0, 1, 0};
  logic clk = 1'b0;
  logic rst;
  logic [5:0] din_a [N];
  logic vld_a [N];
  logic [4:0] out_a [N];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s {x,act,rdy,busy,done} got=%b want=%b at %0t", tag, got, exp, $time);
    end
  endtask
  for (genvar g = 0; g < N; g++) begin : cfg
    localparam int MSB_G = MSBS[g];
    localparam int PAR_G = PARS[g];
    localparam int GAP_G = GAPS[g];
    localparam logic IDL_G = IDLS[g] != 0;
    localparam logic [4:0] IDLE_E = {IDL_G, 4'b0100};
    serial_bit_feeder_if #(.WIDTH(6)) bus ();
    serial_bit_feeder #(.WIDTH(6), .MSB_FIRST(MSB_G), .PARITY_EN(PAR_G), .GAP_CYCLES(GAP_G), .IDLE_LEVEL(IDL_G)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );
    assign bus.din = din_a[g];
    assign bus.din_valid = vld_a[g];
    assign out_a[g] = {bus.x, bus.x_active, bus.din_ready, bus.busy, bus.frame_done};
    logic [4:0] q [$];
    logic [4:0] cur = IDLE_E;
    logic [5:0] d;
    // on acceptance the whole frame's per-cycle outputs are queued at once
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        cur = IDLE_E;
      end else begin
        if (vld_a[g] && cur[2]) begin
          d = din_a[g];
          for (int i = 0; i < 6; i++) q.push_back({d[MSB_G != 0 ? 5 - i : i], 4'b1010});
          if (PAR_G != 0) q.push_back({1'($countones(d) % 2), 4'b1010});
          q.push_back({IDL_G, 1'b0, GAP_G == 0, GAP_G != 0, 1'b1});
          for (int j = 1; j < GAP_G; j++) q.push_back({IDL_G, 4'b0010});
        end
        cur = q.size() > 0 ? q.pop_front() : IDLE_E;
        #1 check($sformatf("cfg%0d", g), out_a[g], cur);
      end
    end
  end
  task automatic randomize_inputs(input bit rnd_valid);
    for (int i = 0; i < N; i++) begin
      din_a[i] = 6'($urandom);
      if (rnd_valid) vld_a[i] = 1'($urandom);
    end
  endtask
  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      vld_a[i] = 1'b0;
      din_a[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) check($sformatf("reset%0d", i), out_a[i], {IDLS[i] != 0, 4'b0100});
    rst = 1'b0;
    din_a = '{6'b101101, 6'b000111, 6'b111111};
    for (int i = 0; i < N; i++) vld_a[i] = 1'b1;
    @(negedge clk);
    repeat (40) begin
      @(negedge clk);
      randomize_inputs(1'b0);
    end
    repeat (400) begin
      @(negedge clk);
      randomize_inputs(1'b1);
    end
    for (int i = 0; i < N; i++) vld_a[i] = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      din_a[i] = 6'b101101;
      vld_a[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) vld_a[i] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) check($sformatf("async_rst%0d", i), out_a[i], {IDLS[i] != 0, 4'b0100});
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) vld_a[i] = 1'b1;
    repeat (150) begin
      @(negedge clk);
      randomize_inputs(1'b1);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
